// File: rtl/timer_arbiter.sv
// timer_arbiter: round-robin arbitration of one shared delay timer.
// The owner holds grant for thr+1 enabled ticks, then done pulses once.
module timer_arbiter #(
  parameter int WIDTH = 9,
  parameter int NREQ  = 4,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_threshold,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic [IW-1:0]         active_id
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] COUNT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] ctr;
  logic [WIDTH-1:0] thr;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    winner;
  logic             win_vld;
  logic [WIDTH-1:0] win_thr;
  logic [NREQ-1:0]  win_oh;
  logic [NREQ-1:0]  own_oh;
  logic             own_req;

  // first requester after rr_ptr, ascending with wrap
  always_comb begin
    winner  = '0;
    win_vld = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!win_vld && req[idx]) begin
        win_vld = 1'b1;
        winner  = IW'(idx);
      end
    end
  end

  // winner threshold and one-hot views of winner and owner
  always_comb begin
    win_thr = req_threshold[int'(winner)*WIDTH +: WIDTH];
    win_oh  = NREQ'(1) << winner;
    own_oh  = NREQ'(1) << active_id;
    own_req = |(req & own_oh);
  end

  // arbitration FSM, delay counter and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ctr       <= '0;
      thr       <= '0;
      rr_ptr    <= IW'(NREQ - 1);
      grant     <= '0;
      done      <= '0;
      busy      <= 1'b0;
      active_id <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= '0;
          if (win_vld) begin
            thr       <= win_thr;
            ctr       <= '0;
            grant     <= win_oh;
            active_id <= winner;
            busy      <= 1'b1;
            state     <= COUNT;
          end
        end
        COUNT: begin
          if (!own_req) begin
            grant  <= '0;
            rr_ptr <= active_id;
            busy   <= 1'b0;
            state  <= IDLE;
          end else if (en) begin
            if (ctr >= thr) begin
              grant  <= '0;
              done   <= own_oh;
              rr_ptr <= active_id;
              state  <= DONE;
            end else begin
              ctr <= ctr + WIDTH'(1);
            end
          end
        end
        DONE: begin
          done  <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          grant <= '0;
          done  <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_arbiter.sv
// tb_timer_arbiter: scoreboard bench for timer_arbiter.
// Expected owner/length pushed at stimulus, popped on each done pulse.
module tb_timer_arbiter;

  localparam int W = 9;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           en;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_threshold;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           busy;
  logic [1:0]     active_id;

  typedef struct {
    int id;
    int len;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   gcnt = 0;
  int   checks = 0;
  int   failures = 0;

  timer_arbiter #(.WIDTH(W), .NREQ(N)) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .req(req),
    .req_threshold(req_threshold),
    .grant(grant),
    .done(done),
    .busy(busy),
    .active_id(active_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_thr(input int i, input int v);
    req_threshold[i*W +: W] = W'(v);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // grant length measurement and done scoreboard
  always @(negedge clk) begin
    if (reset) begin
      gcnt = 0;
    end else begin
      chk("excl",
          ($onehot0(grant) && $onehot0(done) &&
           !(|grant && |done)) ? 32'd1 : 32'd0, 32'd1);
      if (|done) begin
        if (sb.size() == 0) begin
          chk("unexp_done", done, 0);
        end else begin
          e = sb.pop_front();
          chk("done_id", done, 32'd1 << e.id);
          chk("grant_len", gcnt, e.len);
          chk("done_aid", active_id, e.id);
        end
        gcnt = 0;
      end else if (|grant) begin
        gcnt++;
      end else begin
        gcnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    en = 1'b1;
    req = '0;
    req_threshold = '0;
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_aid", active_id, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("idle_grant", grant, 0);
    chk("idle_busy", busy, 0);

    // basic delay, thr=3, threshold change after win ignored
    set_thr(0, 3);
    sb.push_back('{0, 4});
    req = 4'b0001;
    tick();
    chk("s1_grant", grant, 4'b0001);
    chk("s1_busy", busy, 1);
    chk("s1_aid", active_id, 0);
    set_thr(0, 0);
    repeat (3) tick();
    chk("s1_hold", grant, 4'b0001);
    tick();
    chk("s1_done", done, 4'b0001);
    chk("s1_gclr", grant, 0);
    req = '0;
    tick();
    chk("s1_busy_lo", busy, 0);
    chk("s1_done_lo", done, 0);

    // all requesting, thr=0: order 0,1,2,3,0
    pulse_reset();
    req_threshold = '0;
    sb.push_back('{0, 1});
    sb.push_back('{1, 1});
    sb.push_back('{2, 1});
    sb.push_back('{3, 1});
    sb.push_back('{0, 1});
    req = 4'b1111;
    repeat (14) tick();
    req = '0;
    tick();
    chk("s2_busy", busy, 0);
    chk("s2_sb", sb.size(), 0);

    // en toggling, thr=2: done on 3rd enabled edge
    set_thr(0, 2);
    en = 1'b0;
    req = 4'b0001;
    sb.push_back('{0, 5});
    tick();
    chk("s3_grant", grant, 4'b0001);
    for (int k = 1; k <= 5; k++) begin
      en = (k % 2 == 1);
      if (k == 5) chk("s3_nodone", done, 0);
      tick();
    end
    chk("s3_done", done, 4'b0001);
    req = '0;
    en = 1'b1;
    tick();

    // abort: req0 dropped mid-count, req1 served next
    pulse_reset();
    set_thr(0, 5);
    set_thr(1, 0);
    req = 4'b0011;
    tick();
    chk("s4_grant0", grant, 4'b0001);
    tick();
    tick();
    req = 4'b0010;
    tick();
    chk("s4_abort_g", grant, 0);
    chk("s4_abort_d", done, 0);
    chk("s4_abort_b", busy, 0);
    sb.push_back('{1, 1});
    tick();
    chk("s4_grant1", grant, 4'b0010);
    chk("s4_aid1", active_id, 1);
    tick();
    req = '0;
    tick();

    // asynchronous reset mid-count
    set_thr(0, 5);
    req = 4'b0001;
    tick();
    tick();
    tick();
    #3;
    reset = 1'b1;
    #1;
    chk("s5_async_g", grant, 0);
    chk("s5_async_b", busy, 0);
    chk("s5_async_d", done, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    set_thr(3, 0);
    req = 4'b1000;
    sb.push_back('{3, 1});
    tick();
    chk("s5_grant3", grant, 4'b1000);
    tick();
    req = '0;
    tick();
    pulse_reset();
    set_thr(0, 0);
    req = 4'b1001;
    sb.push_back('{0, 1});
    tick();
    chk("s5_grant0", grant, 4'b0001);
    tick();
    req = '0;
    tick();

    // maximum threshold: 512 cycles, no wrap
    set_thr(0, 511);
    req = 4'b0001;
    sb.push_back('{0, 512});
    tick();
    repeat (511) tick();
    chk("s6_hold", grant, 4'b0001);
    chk("s6_nodone", done, 0);
    tick();
    chk("s6_done", done, 4'b0001);
    req = '0;
    tick();
    chk("s6_busy", busy, 0);

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timer_arbiter.md
TIMER_ARBITER -- requirements
Module: timer_arbiter

Interface
REQ-001 Parameter WIDTH, default 9, SHALL set the delay threshold and internal counter width.
REQ-002 Parameter NREQ, default 4, SHALL set the requester count; legal range 2..8.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 en  input  1  SHALL be the tick enable; the counter advances only on edges where en=1.
REQ-006 req  input  NREQ  SHALL be per-requester level requests for the shared delay timer.
REQ-007 req_threshold  input  NREQ*WIDTH  SHALL carry requester i's threshold in bits [i*WIDTH +: WIDTH].
REQ-008 grant  output  NREQ  SHALL be a registered one-hot (or zero) vector marking the timer owner.
REQ-009 done  output  NREQ  SHALL be a registered one-hot single-cycle pulse marking completion for the owner.
REQ-010 busy  output  1  SHALL be registered high whenever the state is not IDLE.
REQ-011 active_id  output  clog2(NREQ)  SHALL be the registered index of the current or last owner.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, COUNT, DONE.
REQ-013 IDLE, any req bit set: SHALL select a winner round-robin, starting at (rr_ptr+1) mod NREQ, ascending with wrap.
REQ-014 On the winning edge: latch the winner's threshold into thr, ctr<=0, grant<=onehot(winner), active_id<=winner, state<=COUNT.
REQ-015 IDLE, req=0: all outputs except active_id SHALL stay 0.
REQ-016 COUNT, en=1, ctr>=thr: grant<=0, done<=onehot(active_id), rr_ptr<=active_id, state<=DONE.
REQ-017 COUNT, en=1, ctr<thr: ctr<=ctr+1.
REQ-018 COUNT, en=0: ctr and all outputs hold.
REQ-019 Delay SHALL be exactly thr+1 enabled COUNT edges; with en constant 1, grant is high for thr+1 cycles.
REQ-020 ctr SHALL never wrap; thr=all-ones finishes when ctr=all-ones.
REQ-021 thr=0 SHALL finish on the first enabled COUNT edge.
REQ-022 req_threshold changes after the winning edge SHALL have no effect on the running delay.
REQ-023 Abort: COUNT with req[active_id]=0 at an edge SHALL set grant<=0, rr_ptr<=active_id and state<=IDLE, with no done pulse.
REQ-024 Abort SHALL take priority over completion on the same edge.
REQ-025 DONE SHALL last one cycle (done high, grant 0), then go unconditionally to IDLE; no arbitration occurs in DONE.
REQ-026 Requests from non-owners SHALL be ignored outside IDLE and serviced only after the owner releases.
REQ-027 A requester still high after its done SHALL lose to any other pending requester in the next IDLE arbitration.
REQ-028 At most one bit of grant and at most one bit of done SHALL be set at any time; grant and done SHALL never be high together.

Reset
REQ-029 reset=1 SHALL immediately, without a clock edge, force:
- state=IDLE
- grant=0, done=0, busy=0, active_id=0
- ctr=0, thr=0
- rr_ptr=NREQ-1, so requester 0 has first priority.
REQ-030 Reset asserted mid-COUNT SHALL abort with no done pulse; after release, arbitration restarts from IDLE.

Verification
REQ-031 en=1, req=0001, thr0=3, edge E0 -> grant=0001 after E0..E3, done=0001 for one cycle after E4, busy low after E5.
REQ-032 req=1111, all thr=0, held high -> grant order 0,1,2,3,0; each grant lasts 1 cycle, followed by a 1-cycle done.
REQ-033 thr0=2, en toggling 1,0,1,0,... -> done after the 3rd enabled COUNT edge, ctr held on en=0 edges.
REQ-034 req0 dropped after 2 COUNT edges with thr0=5 -> grant clears, done never pulses, req1 pending is granted next IDLE edge.
REQ-035 reset pulsed mid-COUNT between edges -> grant/busy low asynchronously; post-release, req=1000 with rr_ptr=3 grants requester 0 first only if req0 is set, else requester 3.
REQ-036 WIDTH=9, thr=511 -> grant held for 512 cycles, ctr never wraps, done then pulses.
